// File: rtl/fnd_scan_controller.sv
// 14-bit binary to 4-digit BCD converter (sequential double-dabble) with a
// time-multiplexed digit-select/value/enable scan output for FND decoders.
module fnd_scan_controller #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int SCAN_HZ       = 1_000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [13:0] i_Value,
  input  logic        i_EN,
  output logic        o_busy,
  output logic        o_ovf,
  output logic [1:0]  o_DigitSelect,
  output logic [3:0]  o_Value,
  output logic        o_EN
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int PW    = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]    state;
  logic [3:0]    iter;
  logic [13:0]   bin;
  logic [15:0]   bcd;
  logic [14:0]   bcd_adj;
  logic [15:0]   disp;
  logic [15:0]   disp_next;
  logic [PW-1:0] pres;
  logic          wrap;
  logic [1:0]    sel_next;
  logic          lead_zero;
  logic          blank;

  assign o_busy = (state != S_IDLE);

  // The thousands nibble never reaches 5 because inputs are clamped to 9999,
  // so only the lower three nibbles need the add-3 correction.
  always_comb begin
    bcd_adj = bcd[14:0];
    for (int k = 0; k < 3; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
      iter  <= '0;
      bin   <= '0;
      bcd   <= '0;
      o_ovf <= 1'b0;
      disp  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_load) begin
            state <= S_CONVERT;
            iter  <= '0;
            bcd   <= '0;
            if (i_Value > 14'd9999) begin
              bin   <= 14'd9999;
              o_ovf <= 1'b1;
            end else begin
              bin   <= i_Value;
              o_ovf <= 1'b0;
            end
          end
        end
        S_CONVERT: begin
          bcd  <= {bcd_adj, bin[13]};
          bin  <= {bin[12:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'd13) state <= S_COMMIT;
        end
        S_COMMIT: begin
          disp  <= bcd;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A commit landing on a scan wrap must feed the freshly selected digit.
  assign disp_next = (state == S_COMMIT) ? bcd : disp;
  assign wrap      = (pres == PW'(DWELL - 1));
  assign sel_next  = o_DigitSelect + 2'd1;

  always_comb begin
    case (sel_next)
      2'd1:    lead_zero = (disp_next[15:4] == 12'd0);
      2'd2:    lead_zero = (disp_next[15:8] == 8'd0);
      2'd3:    lead_zero = (disp_next[15:12] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
    blank = (BLANK_LEADING != 0) && lead_zero;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pres          <= '0;
      o_DigitSelect <= 2'd0;
      o_Value       <= 4'd0;
      o_EN          <= 1'b0;
    end else if (wrap) begin
      pres          <= '0;
      o_DigitSelect <= sel_next;
      o_Value       <= disp_next[4*sel_next +: 4];
      o_EN          <= i_EN & ~blank;
    end else begin
      pres <= pres + PW'(1);
    end
  end

endmodule
